axis_frame_gen: RTL and testbench
=================================

# axis_frame_gen

AXI-Stream frame transmitter driving the slave side of the team's AXI-Stream FIFO (`s_axis_*`) and other stream sinks. On a start command it emits a programmed number of frames, each of programmed byte length, with a deterministic data pattern, a per-beat `tkeep`, `tlast` on the final beat and an optional bad-frame mark in `tuser`, separated by a programmable idle gap. It honours backpressure and serves as traffic source for frame-FIFO bring-up and the drop/overflow paths.

## Interface
- DATA_WIDTH, 8, tdata width; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width (bytes per beat).
- LEN_WIDTH, 16, width of frame_len (bytes).
- CNT_WIDTH, 16, width of frame_count and frames_sent.
- GAP_WIDTH, 8, width of gap_len.
- USER_BAD_FRAME_VALUE, 1'b1, tuser value on last beat of a marked frame (tuser is 1 bit).

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command; sampled only in IDLE.
- stop  in  1  finish current frame, then IDLE.
- frame_len  in  LEN_WIDTH  bytes per frame; 0 = command ignored.
- frame_count  in  CNT_WIDTH  frames per run; 0 = continuous until stop.
- gap_len  in  GAP_WIDTH  idle cycles between frames (tvalid low).
- seed  in  8  first-byte pattern seed.
- mark_bad  in  1  mark every frame of the run bad.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  valid.
- m_axis_tready  in  1  ready.
- m_axis_tlast  out  1  last beat.
- m_axis_tuser  out  1  bad-frame flag, last beat only.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when a run ends.
- frames_sent  out  CNT_WIDTH  frames completed in current/last run; wraps.

## Operation
- States: IDLE, SEND, GAP.
- IDLE: start && frame_len!=0 → latch frame_len, frame_count, gap_len, seed, mark_bad; clear frames_sent; → SEND.
- SEND: beat held until accepted (tvalid && tready); tdata/tkeep/tlast/tuser stable while tvalid && !tready. Beat count = ceil(frame_len/KEEP_WIDTH).
- Last beat: tkeep low (frame_len mod KEEP_WIDTH) bits set, all ones if remainder 0; all other beats all ones. tuser = USER_BAD_FRAME_VALUE if latched mark_bad, else 0; tuser 0 on non-last beats.
- Last beat accepted: frames_sent++; if stop seen during run, or frames_sent+1 == frame_count (count!=0) → IDLE, pulse done; else gap_len==0 → SEND (next frame back-to-back), else → GAP.
- GAP: count gap_len cycles, tvalid low, then SEND. stop in GAP → IDLE, done.
- stop is sticky from assertion to end of current frame; never truncates a frame.
- Pattern (default): byte i of frame = (seed + i) mod 256, restarts per frame; lane j of beat k carries byte k*KEEP_WIDTH+j (little-endian). Masked lanes carry pattern value anyway.
- start while busy ignored.

## Timing
- Reset values: tvalid 0, tlast 0, tuser 0, tdata 0, tkeep 0, busy 0, done 0, frames_sent 0, state IDLE.
- All outputs registered. start sampled in cycle N → tvalid high in N+1.
- With tready constantly high: one beat per cycle, no bubble inside a frame; gap_len 0 gives zero bubble between frames.
- done asserts the cycle after the final accepted beat; busy falls in the same cycle.
- rst mid-frame: tvalid low the following cycle, frame truncated without tlast, counters cleared.

## Configuration
- AXIS_FRAME_GEN_PRBS_EN defined: data from PRBS31 (x^31+x^28+1) LFSR, seeded with {23'h1, seed} at each frame start, advanced 8 steps per byte; tdata lane = 8 LFSR output bits in order. Undefined: incrementing-byte pattern above. Everything else identical.

## Structure
- Package axis_frame_gen_pkg: state enum, PRBS31 taps/length constant, pattern step constant.
- Sub-module axis_frame_gen_pattern: holds pattern state, outputs one beat of DATA_WIDTH bits; inputs load (frame start, seed) and advance (beat accepted).

## Test plan
- DATA_WIDTH 8, frame_len 4, count 2, gap 0, seed 8'h10, tready 1 → tdata 10,11,12,13,10,11,12,13; tlast on beats 4,8; frames_sent 2; done one cycle.
- DATA_WIDTH 32, frame_len 6, count 1 → beat0 tdata 8'h13..10 lanes, tkeep 4'hF; beat1 tkeep 4'h3, tlast 1.
- Random tready (50%) with frame_len 17 → tdata/tkeep/tlast stable while stalled; 17 bytes delivered in order.
- count 0, gap 3, stop mid-frame 2 → frame 2 completes with tlast, exactly 3 low-tvalid cycles between frames, then IDLE, frames_sent 2.
- mark_bad 1, frame_len 3 into frame FIFO with DROP_BAD_FRAME → tuser 1 on beat 3 only; FIFO reports bad frame.
- rst asserted during beat 2 of 5 → tvalid 0 next cycle, busy 0, frames_sent 0; new start accepted afterwards.

Source files
------------

// File: rtl/axis_frame_gen_pkg.sv
// ---------------------------------------------------------------------------
// axis_frame_gen_pkg
// Shared types and constants for the AXI-Stream frame generator:
//   - state_e             : top-level FSM states
//   - PRBS_LEN / PRBS_TAP : PRBS31 polynomial x^31 + x^28 + 1
//   - PRBS_STEPS_PER_BYTE : LFSR shifts per generated byte
//   - PATTERN_STEP        : byte-to-byte increment of the default pattern
//   - prbs_next_byte()    : advances the LFSR by one byte worth of steps
// ---------------------------------------------------------------------------
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int         PRBS_LEN            = 31;
    localparam int         PRBS_TAP            = 28;
    localparam int         PRBS_STEPS_PER_BYTE = 8;
    localparam logic [7:0] PATTERN_STEP        = 8'd1;

    // Fibonacci LFSR: each step shifts in tap31 ^ tap28 at bit 0, so after
    // eight steps bits [7:0] hold the eight new output bits, oldest at bit 7.
    function automatic logic [PRBS_LEN-1:0] prbs_next_byte(input logic [PRBS_LEN-1:0] s);
        logic [PRBS_LEN-1:0] r;
        r = s;
        for (int i = 0; i < PRBS_STEPS_PER_BYTE; i++) begin
            r = {r[PRBS_LEN-2:0], r[PRBS_LEN-1] ^ r[PRBS_TAP-1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_frame_gen_pattern.sv
// ---------------------------------------------------------------------------
// axis_frame_gen_pattern
// Holds the data-pattern state and presents one registered beat of payload.
// Optional feature macro: AXIS_FRAME_GEN_PRBS_EN (PRBS31 payload instead of
// the incrementing-byte payload).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : restart the pattern from seed (frame start); wins over advance
//   advance   : move to the next beat (current beat accepted)
//   seed      : first-byte seed
//   data      : current beat, lane j = byte k*KEEP_WIDTH+j of the frame
// ---------------------------------------------------------------------------
module axis_frame_gen_pattern
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [7:0]            seed,
    output logic [DATA_WIDTH-1:0] data
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

`ifdef AXIS_FRAME_GEN_PRBS_EN
    // lfsr_q is the LFSR state after producing the beat currently in data_q.
    logic [PRBS_LEN-1:0] lfsr_q;
    logic [PRBS_LEN-1:0] lfsr_d;
    logic [PRBS_LEN-1:0] chain [KEEP_WIDTH+1];

    assign chain[0] = load ? {(PRBS_LEN-8)'(1), seed} : lfsr_q;

    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
        assign chain[gi+1]         = prbs_next_byte(chain[gi]);
        assign data_d[gi*8 +: 8]   = chain[gi+1][7:0];
    end

    assign lfsr_d = chain[KEEP_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
            data_q <= '0;
        end else if (load || advance) begin
            lfsr_q <= lfsr_d;
            data_q <= data_d;
        end
    end
`else
    // base_q is the pattern value of lane 0 of the *next* beat.
    logic [7:0] base_q;
    logic [7:0] base_d;
    logic [7:0] src_base;

    assign src_base = load ? seed : base_q;

    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
        assign data_d[gi*8 +: 8] = src_base + 8'(gi) * PATTERN_STEP;
    end

    assign base_d = src_base + 8'(KEEP_WIDTH) * PATTERN_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            data_q <= '0;
        end else if (load || advance) begin
            base_q <= base_d;
            data_q <= data_d;
        end
    end
`endif

    assign data = data_q;

endmodule

// File: rtl/axis_frame_gen.sv
// ---------------------------------------------------------------------------
// axis_frame_gen
// AXI-Stream frame source: on start emits frame_count frames (0 = until stop)
// of frame_len bytes, separated by gap_len idle cycles, with tkeep on the last
// beat, tlast, and an optional bad-frame mark in tuser.
// Optional feature macro: AXIS_FRAME_GEN_PRBS_EN (PRBS31 payload).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   start, stop                     : run control (start only in IDLE)
//   frame_len, frame_count, gap_len : run configuration, latched at start
//   seed, mark_bad                  : pattern seed, bad-frame marking
//   m_axis_*                        : AXI-Stream master
//   busy, done, frames_sent         : status
// ---------------------------------------------------------------------------
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int   DATA_WIDTH           = 8,
    parameter int   KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int   LEN_WIDTH            = 16,
    parameter int   CNT_WIDTH            = 16,
    parameter int   GAP_WIDTH            = 8,
    parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [CNT_WIDTH-1:0]  frame_count,
    input  logic [GAP_WIDTH-1:0]  gap_len,
    input  logic [7:0]            seed,
    input  logic                  mark_bad,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frames_sent
);
    localparam logic [LEN_WIDTH-1:0] KEEP_LEN = LEN_WIDTH'(KEEP_WIDTH);

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [GAP_WIDTH-1:0]   gap_len_q, gap_len_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]             seed_q, seed_d;
    logic                   mark_bad_q, mark_bad_d;
    logic                   stop_seen_q, stop_seen_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;          // bytes left incl. current beat
    logic [CNT_WIDTH-1:0]   frames_sent_q, frames_sent_d;
    logic [KEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   tuser_q, tuser_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   pat_load;
    logic                   pat_advance;
    logic [7:0]             pat_seed;
    logic [CNT_WIDTH-1:0]   frames_inc;
    logic                   present;
    logic                   present_last;
    logic [LEN_WIDTH-1:0]   present_rem;
    logic                   present_mark;
    logic                   finish_run;

    // Lane j is enabled when more than j bytes remain in the frame.
    function automatic logic [KEEP_WIDTH-1:0] keep_for(input logic [LEN_WIDTH-1:0] rem);
        logic [KEEP_WIDTH-1:0] k;
        for (int j = 0; j < KEEP_WIDTH; j++) begin
            k[j] = (rem > LEN_WIDTH'(j));
        end
        return k;
    endfunction

    assign frames_inc = frames_sent_q + CNT_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = count_q;
        gap_len_d     = gap_len_q;
        gap_cnt_d     = gap_cnt_q;
        seed_d        = seed_q;
        mark_bad_d    = mark_bad_q;
        stop_seen_d   = stop_seen_q;
        rem_d         = rem_q;
        frames_sent_d = frames_sent_q;
        tkeep_d       = tkeep_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pat_load      = 1'b0;
        pat_advance   = 1'b0;
        pat_seed      = seed_q;
        present       = 1'b0;
        present_last  = 1'b0;
        present_rem   = rem_q;
        present_mark  = mark_bad_q;
        finish_run    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (frame_len != '0)) begin
                    len_d         = frame_len;
                    count_d       = frame_count;
                    gap_len_d     = gap_len;
                    seed_d        = seed;
                    mark_bad_d    = mark_bad;
                    stop_seen_d   = 1'b0;
                    frames_sent_d = '0;
                    busy_d        = 1'b1;
                    pat_load      = 1'b1;
                    pat_seed      = seed;
                    present       = 1'b1;
                    present_rem   = frame_len;
                    present_mark  = mark_bad;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                stop_seen_d = stop_seen_q | stop;
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        frames_sent_d = frames_inc;
                        if (stop_seen_q || stop || ((count_q != '0) && (frames_inc == count_q))) begin
                            finish_run = 1'b1;
                        end else begin
                            // Reload now so the first beat is ready whether
                            // the next frame follows at once or after a gap.
                            pat_load = 1'b1;
                            if (gap_len_q == '0) begin
                                present     = 1'b1;
                                present_rem = len_q;
                            end else begin
                                tvalid_d  = 1'b0;
                                tlast_d   = 1'b0;
                                tuser_d   = 1'b0;
                                gap_cnt_d = gap_len_q;
                                state_d   = ST_GAP;
                            end
                        end
                    end else begin
                        pat_advance = 1'b1;
                        present     = 1'b1;
                        present_rem = rem_q - KEEP_LEN;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    finish_run = 1'b1;
                end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    present     = 1'b1;
                    present_rem = len_q;
                    state_d     = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (present) begin
            present_last = (present_rem <= KEEP_LEN);
            rem_d        = present_rem;
            tvalid_d     = 1'b1;
            tkeep_d      = keep_for(present_rem);
            tlast_d      = present_last;
            tuser_d      = (present_last && present_mark) ? USER_BAD_FRAME_VALUE : 1'b0;
        end

        if (finish_run) begin
            state_d     = ST_IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            tuser_d     = 1'b0;
            tkeep_d     = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            count_q       <= '0;
            gap_len_q     <= '0;
            gap_cnt_q     <= '0;
            seed_q        <= '0;
            mark_bad_q    <= 1'b0;
            stop_seen_q   <= 1'b0;
            rem_q         <= '0;
            frames_sent_q <= '0;
            tkeep_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            count_q       <= count_d;
            gap_len_q     <= gap_len_d;
            gap_cnt_q     <= gap_cnt_d;
            seed_q        <= seed_d;
            mark_bad_q    <= mark_bad_d;
            stop_seen_q   <= stop_seen_d;
            rem_q         <= rem_d;
            frames_sent_q <= frames_sent_d;
            tkeep_q       <= tkeep_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    axis_frame_gen_pattern #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .load    (pat_load),
        .advance (pat_advance),
        .seed    (pat_seed),
        .data    (m_axis_tdata)
    );

    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = frames_sent_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_gen
// Directed bench for axis_frame_gen: an 8-bit instance for sequencing, gaps,
// stop, backpressure, bad-frame marking and reset, plus a 32-bit instance for
// tkeep on a partial last beat.
// ---------------------------------------------------------------------------
module tb_axis_frame_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        start = 0, stop = 0, mark_bad = 0, tready = 1;
    logic [15:0] frame_len = 0, frame_count = 0;
    logic [7:0]  gap_len = 0, seed = 0;
    logic [7:0]  tdata;
    logic [0:0]  tkeep;
    logic        tvalid, tlast, tuser, busy, done;
    logic [15:0] frames_sent;

    // 32-bit instance
    logic        start_w = 0, stop_w = 0, mark_bad_w = 0, tready_w = 1;
    logic [15:0] frame_len_w = 0, frame_count_w = 0;
    logic [7:0]  gap_len_w = 0, seed_w = 0;
    logic [31:0] tdata_w;
    logic [3:0]  tkeep_w;
    logic        tvalid_w, tlast_w, tuser_w, busy_w, done_w;
    logic [15:0] frames_sent_w;

    axis_frame_gen #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .frame_len(frame_len), .frame_count(frame_count), .gap_len(gap_len),
        .seed(seed), .mark_bad(mark_bad),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
        .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    axis_frame_gen #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start_w), .stop(stop_w),
        .frame_len(frame_len_w), .frame_count(frame_count_w), .gap_len(gap_len_w),
        .seed(seed_w), .mark_bad(mark_bad_w),
        .m_axis_tdata(tdata_w), .m_axis_tkeep(tkeep_w), .m_axis_tvalid(tvalid_w),
        .m_axis_tready(tready_w), .m_axis_tlast(tlast_w), .m_axis_tuser(tuser_w),
        .busy(busy_w), .done(done_w), .frames_sent(frames_sent_w)
    );

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } beat_t;

    beat_t beats[$];
    int    done_cyc[$];
    logic  busy_at_done;
    int    stall_viol;
    bit    timed_out;

    // Runs the 8-bit instance after a start pulse, recording accepted beats,
    // done pulses and any change of a stalled beat. Cycle 0 is the first
    // cycle after the start command was sampled.
    task automatic collect(input int max_cyc, input bit rand_ready, input int stop_at);
        int since_done;
        bit seen, pstall, stop_sent;
        logic [7:0] pd;
        logic pl, pu;
        beats.delete();
        done_cyc.delete();
        stall_viol = 0;
        seen = 0; pstall = 0; stop_sent = 0; since_done = 0;
        busy_at_done = 1'bx;
        pd = '0; pl = 0; pu = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (stop_at >= 0 && beats.size() == stop_at && !stop_sent) begin
                stop = 1'b1;
                stop_sent = 1;
            end
            if (pstall && !(tvalid === 1'b1 && tdata === pd && tlast === pl && tuser === pu))
                stall_viol++;
            if (done === 1'b1) begin
                done_cyc.push_back(cyc);
                busy_at_done = busy;
                seen = 1;
            end
            if (seen) since_done++;
            tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid === 1'b1 && tready) begin
                beats.push_back('{data: tdata, last: tlast, user: tuser, cyc: cyc});
                $display("beat %0d cyc %0d data %02h last %0b user %0b",
                         beats.size() - 1, cyc, tdata, tlast, tuser);
            end
            pstall = (tvalid === 1'b1) && !tready;
            pd = tdata; pl = tlast; pu = tuser;
            if (since_done >= 3) break;
        end
        timed_out = !seen;
        tready = 1'b1;
        stop   = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tvalid, tlast, tuser, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %05b want 00000", {tvalid, tlast, tuser, busy, done});
        end
        vectors++;
        if (tdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_tdata got %02h want 00", tdata);
        end
        vectors++;
        if (tkeep !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tkeep got %0b want 0", tkeep);
        end
        vectors++;
        if (frames_sent !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_frames_sent got %0d want 0", frames_sent);
        end
        vectors++;
        if ({tvalid_w, busy_w, tkeep_w} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_wide got %06b want 000000", {tvalid_w, busy_w, tkeep_w});
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_len;
        @(negedge clk);
        frame_len = 0; frame_count = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({tvalid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_len got valid/busy %02b want 00", {tvalid, busy});
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        frame_len = 4; frame_count = 2; gap_len = 0; seed = 8'h10; mark_bad = 0; start = 1'b1;
        collect(40, 0, -1);
        vectors++;
        if (timed_out || beats.size() != 8) begin
            miscompares++;
            $display("FAIL basic_count got %0d beats (timeout %0b) want 8", beats.size(), timed_out);
        end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            vectors++;
            if (beats[i].data !== 8'(8'h10 + (i % 4)) || beats[i].last !== (i % 4 == 3) || beats[i].cyc != i) begin
                miscompares++;
                $display("FAIL basic_beat[%0d] got data %02h last %0b cyc %0d want %02h %0b %0d",
                         i, beats[i].data, beats[i].last, beats[i].cyc, 8'(8'h10 + (i % 4)), (i % 4 == 3), i);
            end
        end
        vectors++;
        if (done_cyc.size() != 1 || done_cyc[0] != 8 || busy_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done got %0d pulses first cyc %0d busy %0b want 1 at 8 busy 0",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, busy_at_done);
        end
        vectors++;
        if (frames_sent !== 16'd2) begin
            miscompares++;
            $display("FAIL basic_frames_sent got %0d want 2", frames_sent);
        end
    endtask

    task automatic test_wide;
        @(negedge clk);
        frame_len_w = 6; frame_count_w = 1; gap_len_w = 0; seed_w = 8'h10; tready_w = 1; start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        vectors++;
        if ({tvalid_w, tdata_w, tkeep_w, tlast_w} !== {1'b1, 32'h13121110, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL wide_beat0 got v%0b %08h k%h l%0b want v1 13121110 kF l0",
                     tvalid_w, tdata_w, tkeep_w, tlast_w);
        end
        @(negedge clk);
        vectors++;
        if ({tvalid_w, tdata_w, tkeep_w, tlast_w, tuser_w} !== {1'b1, 32'h17161514, 4'h3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wide_beat1 got v%0b %08h k%h l%0b u%0b want v1 17161514 k3 l1 u0",
                     tvalid_w, tdata_w, tkeep_w, tlast_w, tuser_w);
        end
        @(negedge clk);
        vectors++;
        if ({done_w, busy_w, tvalid_w} !== 3'b100 || frames_sent_w !== 16'd1) begin
            miscompares++;
            $display("FAIL wide_done got done/busy/valid %03b sent %0d want 100 sent 1",
                     {done_w, busy_w, tvalid_w}, frames_sent_w);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        frame_len = 17; frame_count = 1; gap_len = 0; seed = 8'hF0; mark_bad = 0; start = 1'b1;
        collect(400, 1, -1);
        vectors++;
        if (timed_out || beats.size() != 17) begin
            miscompares++;
            $display("FAIL bp_count got %0d beats (timeout %0b) want 17", beats.size(), timed_out);
        end
        for (int i = 0; i < beats.size() && i < 17; i++) begin
            vectors++;
            if (beats[i].data !== 8'(8'hF0 + i) || beats[i].last !== (i == 16) || beats[i].user !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_beat[%0d] got %02h last %0b user %0b want %02h %0b 0",
                         i, beats[i].data, beats[i].last, beats[i].user, 8'(8'hF0 + i), (i == 16));
            end
        end
        vectors++;
        if (stall_viol != 0) begin
            miscompares++;
            $display("FAIL bp_stall_stable got %0d changes want 0", stall_viol);
        end
    endtask

    task automatic test_stop_gap;
        @(negedge clk);
        frame_len = 4; frame_count = 0; gap_len = 3; seed = 8'h20; mark_bad = 0; start = 1'b1;
        collect(60, 0, 5);
        vectors++;
        if (timed_out || beats.size() != 8) begin
            miscompares++;
            $display("FAIL stop_count got %0d beats (timeout %0b) want 8", beats.size(), timed_out);
        end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            vectors++;
            if (beats[i].data !== 8'(8'h20 + (i % 4)) || beats[i].last !== (i % 4 == 3)) begin
                miscompares++;
                $display("FAIL stop_beat[%0d] got %02h last %0b want %02h %0b",
                         i, beats[i].data, beats[i].last, 8'(8'h20 + (i % 4)), (i % 4 == 3));
            end
        end
        if (beats.size() >= 5) begin
            vectors++;
            if (beats[4].cyc - beats[3].cyc - 1 != 3) begin
                miscompares++;
                $display("FAIL stop_gap got %0d idle cycles want 3", beats[4].cyc - beats[3].cyc - 1);
            end
        end
        vectors++;
        if (done_cyc.size() != 1 || frames_sent !== 16'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_end got %0d done pulses sent %0d busy %0b want 1 sent 2 busy 0",
                     done_cyc.size(), frames_sent, busy);
        end
    endtask

    task automatic test_mark_bad;
        @(negedge clk);
        frame_len = 3; frame_count = 2; gap_len = 1; seed = 8'h00; mark_bad = 1; start = 1'b1;
        collect(40, 0, -1);
        mark_bad = 0;
        vectors++;
        if (timed_out || beats.size() != 6) begin
            miscompares++;
            $display("FAIL bad_count got %0d beats (timeout %0b) want 6", beats.size(), timed_out);
        end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            vectors++;
            if (beats[i].user !== (i % 3 == 2) || beats[i].last !== (i % 3 == 2)) begin
                miscompares++;
                $display("FAIL bad_beat[%0d] got user %0b last %0b want %0b", i,
                         beats[i].user, beats[i].last, (i % 3 == 2));
            end
        end
        if (beats.size() >= 4) begin
            vectors++;
            if (beats[3].cyc - beats[2].cyc - 1 != 1) begin
                miscompares++;
                $display("FAIL bad_gap got %0d idle cycles want 1", beats[3].cyc - beats[2].cyc - 1);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        frame_len = 5; frame_count = 0; gap_len = 0; seed = 8'h40; mark_bad = 0; tready = 1; start = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        // Cycle 6: second beat of the second frame.
        vectors++;
        if (tvalid !== 1'b1 || tdata !== 8'h41 || frames_sent !== 16'd1) begin
            miscompares++;
            $display("FAIL rstmid_before got v%0b %02h sent %0d want v1 41 sent 1", tvalid, tdata, frames_sent);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tvalid, tlast, busy, done} !== 4'b0 || frames_sent !== 16'd0) begin
            miscompares++;
            $display("FAIL rstmid_after got v/l/b/d %04b sent %0d want 0000 sent 0",
                     {tvalid, tlast, busy, done}, frames_sent);
        end
        rst = 1'b0;
        frame_len = 2; frame_count = 1; seed = 8'h55; start = 1'b1;
        collect(30, 0, -1);
        vectors++;
        if (timed_out || beats.size() != 2 || beats[0].data !== 8'h55 || beats[1].data !== 8'h56 ||
            beats[1].last !== 1'b1 || beats[0].cyc != 0) begin
            miscompares++;
            $display("FAIL rstmid_restart got %0d beats (timeout %0b) want 55,56 from cycle 0",
                     beats.size(), timed_out);
        end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_basic();
        test_wide();
        test_backpressure();
        test_stop_gap();
        test_mark_bad();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
